// File: rtl/id_ex_pkg.sv
// Shared types and constants for the decode-to-execute pipeline register.
// Holds operand/index width defaults, the packed control bundle and the bubble control.
// Occupancy states are encoded directly from the (main, skid) valid bits.
package id_ex_pkg;

    localparam int DEFAULT_XLEN   = 64;
    localparam int DEFAULT_REG_AW = 5;

    // Decoded control bundle; alu_op occupies the most significant bits.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Bit offsets of each control field inside the packed bundle.
    localparam int CTRL_ALU_OP_LSB  = 6;
    localparam int CTRL_ALU_SRC     = 5;
    localparam int CTRL_BRANCH      = 4;
    localparam int CTRL_MEM_READ    = 3;
    localparam int CTRL_MEM_WRITE   = 2;
    localparam int CTRL_MEM_TO_REG  = 1;
    localparam int CTRL_REG_WRITE   = 0;

    // All-zero control: no register write, no memory access, no branch.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    // Occupancy state = {main valid, skid valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

endpackage

// File: rtl/id_ex_entry.sv
// One pipeline slot: valid bit plus payload, loaded/cleared by the owning stage.
// Latency: load visible one cycle after the enabling edge.
// Backpressure: none locally; kill invalidates and zeroes the control field (payload LSBs).
module id_ex_entry
    import id_ex_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic         kill_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    // Next state: kill beats load beats clear; data is kept when only invalidated.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (kill_i) begin
            vld_d              = 1'b0;
            dat_d[CTRL_W-1:0]  = CTRL_BUBBLE;
        end else if (ld_i) begin
            vld_d = 1'b1;
            dat_d = d_i;
        end else if (clr_i) begin
            vld_d = 1'b0;
        end
    end

    // Slot register with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = dat_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a 2-entry skid buffer; optional writeback bypass via ID_EX_WB_BYPASS_EN.
// Latency: 1 cycle from input accept to out_valid; 1 instruction/cycle when out_ready stays high.
// Backpressure: in_ready = ~skid valid straight from a flop, so it never depends combinationally on out_ready.
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
`ifdef ID_EX_WB_BYPASS_EN
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
`endif
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam int PW = 4*XLEN + 3*REG_AW + CTRL_W;

    logic [XLEN-1:0] rs1_src, rs2_src, rs1_cap, rs2_cap;
    logic [PW-1:0]   in_pl, m_d, m_pl, s_pl;
    logic            m_vld, s_vld, in_acc, out_acc;
    logic            m_ld, m_from_s, m_clr, s_ld, s_clr;
    state_e          state;

`ifdef ID_EX_WB_BYPASS_EN
    // A writeback landing this cycle wins over the stale register-file read.
    assign rs1_src = (wb_we && (wb_rd != '0) && (wb_rd == in_rs1)) ? wb_data : in_rs1_data;
    assign rs2_src = (wb_we && (wb_rd != '0) && (wb_rd == in_rs2)) ? wb_data : in_rs2_data;
`else
    assign rs1_src = in_rs1_data;
    assign rs2_src = in_rs2_data;
`endif

    // x0 always reads as zero regardless of what the register file returned.
    assign rs1_cap = (in_rs1 == '0) ? '0 : rs1_src;
    assign rs2_cap = (in_rs2 == '0) ? '0 : rs2_src;

    // Control sits in the LSBs so the slot can bubble it on flush.
    assign in_pl = {in_pc, rs1_cap, rs2_cap, in_imm, in_rs1, in_rs2, in_rd, in_ctrl};

    assign in_ready  = ~s_vld;
    assign out_valid = m_vld;
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = m_vld & out_ready;

    // Occupancy FSM: decide which slot loads or drains this cycle.
    always_comb begin
        m_ld     = 1'b0;
        m_from_s = 1'b0;
        m_clr    = 1'b0;
        s_ld     = 1'b0;
        s_clr    = 1'b0;
        state    = state_e'({m_vld, s_vld});
        case (state)
            ST_EMPTY: begin
                m_ld = in_acc;
            end
            ST_ONE: begin
                if (in_acc && out_acc) begin
                    m_ld = 1'b1;
                end else if (in_acc) begin
                    s_ld = 1'b1;
                end else if (out_acc) begin
                    m_clr = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_acc) begin
                    m_ld     = 1'b1;
                    m_from_s = 1'b1;
                    s_clr    = 1'b1;
                end
            end
            default: begin
                // Skid-only occupancy is unreachable; drop it.
                s_clr = 1'b1;
            end
        endcase
    end

    assign m_d = m_from_s ? s_pl : in_pl;

    id_ex_entry #(.W(PW)) u_main (
        .clk    (clk),
        .reset  (reset),
        .ld_i   (m_ld),
        .clr_i  (m_clr),
        .kill_i (flush),
        .d_i    (m_d),
        .vld_o  (m_vld),
        .q_o    (m_pl)
    );

    id_ex_entry #(.W(PW)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .ld_i   (s_ld),
        .clr_i  (s_clr),
        .kill_i (flush),
        .d_i    (in_pl),
        .vld_o  (s_vld),
        .q_o    (s_pl)
    );

    assign {out_pc, out_rs1_data, out_rs2_data, out_imm,
            out_rs1, out_rs2, out_rd, out_ctrl} = m_pl;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: scoreboard of accepted instructions plus per-scenario checks.
// Drives inputs 1 time unit after posedge; the output monitor samples on negedge.
// Covers reset, streaming, backpressure/skid, x0, flush, reset-while-full and (if enabled) bypass.
module tb_id_ex_pipe;
    import id_ex_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [9:0]  ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [9:0]  in_ctrl;
    logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [9:0]  out_ctrl;
`ifdef ID_EX_WB_BYPASS_EN
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
`endif

    exp_t exp_q[$];
    exp_t mon_got, mon_exp;
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_ctrl      (in_ctrl),
`ifdef ID_EX_WB_BYPASS_EN
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
`endif
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_ctrl     (out_ctrl)
    );

    // Every output handshake must match the oldest outstanding accepted instruction.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_got = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd, out_ctrl};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc=%h, expected no output", out_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                popped++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_order: got %h, want %h", mon_got, mon_exp);
                end
            end
        end
    end

    function automatic logic [63:0] model_rs(input logic [4:0] idx, input logic [63:0] d);
        if (idx == 5'd0) return 64'd0;
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_we && wb_rd != 5'd0 && wb_rd == idx) return wb_data;
`endif
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Present one instruction; record it as expected only if it will be accepted.
    task automatic send(input logic [63:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] imm, input logic [9:0] c);
        exp_t e;
        in_valid = 1'b1; in_pc = pc; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_ctrl = c;
        e.pc = pc; e.rs1_data = model_rs(r1, d1); e.rs2_data = model_rs(r2, d2);
        e.imm = imm; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.ctrl = c;
        if (in_ready === 1'b1 && flush === 1'b0 && reset === 1'b0) exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); out_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, want 1", in_ready); end
        checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rst_out_pc: got %h, want 0", out_pc); end
        checks++; if (out_rs1_data !== 64'd0) begin errors++; $display("FAIL rst_rs1_data: got %h, want 0", out_rs1_data); end
        checks++; if (out_ctrl !== 10'd0) begin errors++; $display("FAIL rst_ctrl: got %h, want 0", out_ctrl); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(64'h1000, 5'd5, 5'd7, 5'd3, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 10'h2A1);
        tick(); idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, want 1", out_valid); end
        checks++; if (out_rs1_data !== 64'd5) begin errors++; $display("FAIL basic_rs1_data: got %h, want 5", out_rs1_data); end
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL basic_imm: got %h, want fffffffffffffffc", out_imm); end
        checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL basic_rd: got %0d, want 3", out_rd); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b, want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = popped;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(64'h2000 + 64'(i * 4), 5'(i + 1), 5'(i + 2), 5'(i + 3),
                 64'(100 + i), 64'(200 + i), 64'(i), 10'(i * 37));
            tick();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b, want 1", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b, want 1", i, out_valid); end
        end
        idle();
        tick(); tick();
        checks++; if (popped - p0 !== 8) begin errors++; $display("FAIL b2b_count: got %0d, want 8", popped - p0); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_left: got %0d, want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int p0;
        p0 = popped;
        out_ready = 1'b0;
        send(64'h3000, 5'd1, 5'd2, 5'd3, 64'h11, 64'h12, 64'h13, 10'h101);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b, want 1", in_ready); end
        send(64'h3004, 5'd4, 5'd5, 5'd6, 64'h21, 64'h22, 64'h23, 10'h102);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b, want 0", in_ready); end
        checks++; if (out_pc !== 64'h3000) begin errors++; $display("FAIL bp_hold1: got %h, want 3000", out_pc); end
        send(64'h3008, 5'd7, 5'd8, 5'd9, 64'h31, 64'h32, 64'h33, 10'h103);
        tick();
        checks++; if (out_pc !== 64'h3000) begin errors++; $display("FAIL bp_hold2: got %h, want 3000", out_pc); end
        checks++; if (out_rs1_data !== 64'h11) begin errors++; $display("FAIL bp_hold_data: got %h, want 11", out_rs1_data); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 64'h3004) begin errors++; $display("FAIL bp_second: got %h, want 3004", out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b, want 1", in_ready); end
        send(64'h3008, 5'd7, 5'd8, 5'd9, 64'h31, 64'h32, 64'h33, 10'h103);
        tick(); idle();
        checks++; if (out_pc !== 64'h3008) begin errors++; $display("FAIL bp_third: got %h, want 3008", out_pc); end
        tick(); tick();
        checks++; if (popped - p0 !== 3) begin errors++; $display("FAIL bp_count: got %0d, want 3", popped - p0); end
    endtask

    task automatic test_x0();
        out_ready = 1'b1;
        send(64'h4000, 5'd0, 5'd0, 5'd1, 64'h55, 64'h66, 64'd0, 10'h001);
        tick(); idle();
        checks++; if (out_rs1_data !== 64'd0) begin errors++; $display("FAIL x0_rs1: got %h, want 0", out_rs1_data); end
        checks++; if (out_rs2_data !== 64'd0) begin errors++; $display("FAIL x0_rs2: got %h, want 0", out_rs2_data); end
        send(64'h4004, 5'd0, 5'd9, 5'd1, 64'h55, 64'd9, 64'd0, 10'h001);
        tick(); idle();
        checks++; if (out_rs2_data !== 64'd9) begin errors++; $display("FAIL x0_nonzero: got %h, want 9", out_rs2_data); end
        tick();
    endtask

    task automatic test_flush();
        int p0;
        out_ready = 1'b0;
        send(64'h5000, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3, 10'h3FF);
        tick();
        send(64'h5004, 5'd1, 5'd2, 5'd3, 64'h4, 64'h5, 64'h6, 10'h3FE);
        tick();
        flush = 1'b1;
        send(64'h5008, 5'd1, 5'd2, 5'd3, 64'h7, 64'h8, 64'h9, 10'h3FD);
        tick();
        flush = 1'b0; idle();
        exp_q.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, want 0", out_valid); end
        checks++; if (out_ctrl !== 10'd0) begin errors++; $display("FAIL flush_ctrl: got %h, want 0", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b, want 1", in_ready); end
        checks++; if (out_pc !== 64'h5000) begin errors++; $display("FAIL flush_data_kept: got %h, want 5000", out_pc); end
        p0 = popped;
        out_ready = 1'b1;
        flush = 1'b1;
        send(64'h500C, 5'd1, 5'd2, 5'd3, 64'hA, 64'hB, 64'hC, 10'h3FC);
        tick();
        flush = 1'b0; idle();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b, want 0", out_valid); end
        checks++; if (popped !== p0) begin errors++; $display("FAIL flush_no_output: got %0d, want %0d", popped, p0); end
    endtask

    task automatic test_reset_full();
        int p0;
        out_ready = 1'b0;
        send(64'h6000, 5'd1, 5'd2, 5'd3, 64'h61, 64'h62, 64'h63, 10'h155);
        tick();
        send(64'h6004, 5'd4, 5'd5, 5'd6, 64'h64, 64'h65, 64'h66, 10'h0AA);
        tick(); idle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rf_full: got %b, want 0", in_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b, want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_ready: got %b, want 1", in_ready); end
        checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rf_pc: got %h, want 0", out_pc); end
        checks++; if (out_rs2_data !== 64'd0) begin errors++; $display("FAIL rf_rs2_data: got %h, want 0", out_rs2_data); end
        checks++; if (out_imm !== 64'd0) begin errors++; $display("FAIL rf_imm: got %h, want 0", out_imm); end
        checks++; if (out_ctrl !== 10'd0) begin errors++; $display("FAIL rf_ctrl: got %h, want 0", out_ctrl); end
        p0 = popped;
        out_ready = 1'b1;
        tick(); tick();
        checks++; if (popped !== p0) begin errors++; $display("FAIL rf_no_output: got %0d, want %0d", popped, p0); end
    endtask

`ifdef ID_EX_WB_BYPASS_EN
    task automatic test_bypass();
        out_ready = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 64'hABCD;
        send(64'h7000, 5'd4, 5'd9, 5'd2, 64'h44, 64'd9, 64'd0, 10'h021);
        tick(); idle();
        checks++; if (out_rs2_data !== 64'hABCD) begin errors++; $display("FAIL byp_hit: got %h, want abcd", out_rs2_data); end
        checks++; if (out_rs1_data !== 64'h44) begin errors++; $display("FAIL byp_other: got %h, want 44", out_rs1_data); end
        wb_rd = 5'd0;
        send(64'h7004, 5'd4, 5'd9, 5'd2, 64'h44, 64'd9, 64'd0, 10'h021);
        tick(); idle();
        checks++; if (out_rs2_data !== 64'd9) begin errors++; $display("FAIL byp_rd0: got %h, want 9", out_rs2_data); end
        wb_we = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_ctrl = '0;
`ifdef ID_EX_WB_BYPASS_EN
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_x0();
        test_flush();
        test_reset_full();
`ifdef ID_EX_WB_BYPASS_EN
        test_bypass();
`endif
        tick();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d, want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
